mdu_core: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO result registers. It is the sequential companion to the single-cycle ALU in the EX stage of the pipelined MIPS core. It accepts one operation per start pulse, holds `busy` for a fixed, parametrised latency, then commits results to HI/LO. The hazard unit stalls `mult`/`div`/`mf*`/`mt*` instructions on `busy`.

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_calc.sv | 85 ++++++++
 rtl/mdu_core.sv | 128 ++++++++++++
 tb/tb_mdu_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state type and op classification for the MDU.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are active only with MDU_MADD_EN.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    IDLE,
    RUN
  } mdu_state_e;

  // Multi-cycle ops: the ones that raise busy.
  function automatic logic is_muldiv(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) ||
        (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD)  || (op == OP_MADDU) ||
             (op == OP_MSUB)  || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational HI/LO result from latched operands.
// in: op, a, b, hi, lo   out: next_hi, next_lo   (MDU_MADD_EN adds accumulate)
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  localparam int W2 = 2 * WIDTH;

  logic            sgn_mul;
  logic [W2-1:0]   mx;
  logic [W2-1:0]   my;
  logic [W2-1:0]   prod;

  // One multiplier: sign- or zero-extend to 2W, keep the low 2W bits.
  assign sgn_mul = (op == OP_MULT) || (op == OP_MADD) ||
                   (op == OP_MSUB);
  assign mx   = {{WIDTH{sgn_mul & a[WIDTH-1]}}, a};
  assign my   = {{WIDTH{sgn_mul & b[WIDTH-1]}}, b};
  assign prod = mx * my;

  logic             sgn_div;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Signed divide on magnitudes; MIN/-1 falls out as q=MIN, r=0.
  assign sgn_div  = (op == OP_DIV);
  assign a_neg    = sgn_div & a[WIDTH-1];
  assign b_neg    = sgn_div & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign b_safe   = div_zero ? WIDTH'(1) : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
  logic [W2-1:0] acc;
  logic [W2-1:0] acc_res;
  logic          acc_sub;

  assign acc     = {hi, lo};
  assign acc_sub = (op == OP_MSUB) || (op == OP_MSUBU);
  assign acc_res = acc_sub ? acc - prod : acc + prod;
`endif

  always_comb begin
    next_hi = hi;
    next_lo = lo;
    case (op)
      OP_MULT, OP_MULTU: {next_hi, next_lo} = prod;
      OP_DIV, OP_DIVU: begin
        if (!div_zero) begin
          next_hi = rem;
          next_lo = quo;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
        {next_hi, next_lo} = acc_res;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle mul/div FSM with HI/LO registers and read mux.
// clk, reset, start, op, src_a, src_b -> busy, hi, lo, rd_data (MDU_MADD_EN)
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ?
                         MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] nhi;
  logic [WIDTH-1:0] nlo;

  logic accept;
  logic load;
  logic commit;
  logic wr_hi;
  logic wr_lo;

  // The final RUN cycle also accepts, giving zero-bubble issue.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      IDLE: accept = start;
      RUN: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          accept  = start;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (is_muldiv(op)) begin
        load    = 1'b1;
        state_d = RUN;
      end
      wr_hi = (op == OP_MTHI);
      wr_lo = (op == OP_MTLO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
    end else if (load) begin
      cnt_q <= is_div(op) ? CNT_W'(DIV_CYCLES - 1) :
                            CNT_W'(MUL_CYCLES - 1);
      op_q  <= op;
      a_q   <= src_a;
      b_q   <= src_b;
    end else if (state_q == RUN && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi      (hi),
    .lo      (lo),
    .next_hi (nhi),
    .next_lo (nlo)
  );

  // An MT* issued on the commit edge is program-later, so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (commit) begin
        hi <= nhi;
        lo <= nlo;
      end
      if (wr_hi) hi <= src_a;
      if (wr_lo) lo <= src_a;
    end
  end

  assign busy = (state_q == RUN);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (op == OP_MFHI): rd_data = hi;
      (op == OP_MFLO): rd_data = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: directed table plus back-to-back and reset-abort sequences.
// Honours MDU_MADD_EN for the accumulate vectors.
module tb_mdu_core;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  mdu_core #(
    .WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int c,
                     input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.cyc = c; v.ehi = eh; v.elo = el;
    tbl.push_back(v);
  endtask

  // Returns #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = OP_NOP;
    src_a = '0; src_b = '0;

    add(OP_MULT,  32'hFFFFFFFD, 32'd7,        MC,
        32'hFFFFFFFF, 32'hFFFFFFEB);
    add(OP_DIV,   32'hFFFFFFF9, 32'd2,        DC,
        32'hFFFFFFFF, 32'hFFFFFFFD);
    add(OP_MTHI,  32'h11,       32'd0,        0,
        32'h11,       32'hFFFFFFFD);
    add(OP_MTLO,  32'h22,       32'd0,        0,
        32'h11,       32'h22);
    add(OP_DIVU,  32'd5,        32'd0,        DC,
        32'h11,       32'h22);
    add(OP_DIV,   32'd5,        32'd0,        DC,
        32'h11,       32'h22);
    add(OP_NOP,   32'h99,       32'h99,       0,
        32'h11,       32'h22);
    add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, DC,
        32'h0,        32'h80000000);
    add(OP_DIVU,  32'hFFFFFFFF, 32'h10,       DC,
        32'hF,        32'h0FFFFFFF);
    add(OP_DIV,   32'd7,        32'hFFFFFFFE, DC,
        32'h1,        32'hFFFFFFFD);
    add(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MC,
        32'hFFFFFFFE, 32'h1);
    add(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, MC,
        32'h0,        32'h1);
    add(OP_MULT,  32'h80000000, 32'h80000000, MC,
        32'h40000000, 32'h0);
    add(OP_MTHI,  32'h0,        32'd0,        0,
        32'h0,        32'h0);
    add(OP_MTLO,  32'd10,       32'd0,        0,
        32'h0,        32'hA);
`ifdef MDU_MADD_EN
    add(OP_MADD,  32'd3,        32'd4,        MC,
        32'h0,        32'd22);
    add(OP_MSUBU, 32'd1,        32'd23,       MC,
        32'hFFFFFFFF, 32'hFFFFFFFF);
    add(OP_MADDU, 32'hFFFFFFFF, 32'd2,        MC,
        32'h1,        32'hFFFFFFFD);
    add(OP_MSUB,  32'd2,        32'hFFFFFFFD, MC,
        32'h2,        32'h3);
`else
    add(OP_MADD,  32'd3,        32'd4,        0,
        32'h0,        32'hA);
    add(OP_MSUBU, 32'd1,        32'd23,       0,
        32'h0,        32'hA);
    add(OP_MADDU, 32'hFFFFFFFF, 32'd2,        0,
        32'h0,        32'hA);
    add(OP_MSUB,  32'd2,        32'hFFFFFFFD, 0,
        32'h0,        32'hA);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d cycles", i), n, tbl[i].cyc);
      chk($sformatf("vec%0d hi", i), hi, tbl[i].ehi);
      chk($sformatf("vec%0d lo", i), lo, tbl[i].elo);
      @(negedge clk);
      op = OP_MFHI;
      #1 chk($sformatf("vec%0d rd mfhi", i), rd_data, tbl[i].ehi);
      op = OP_MFLO;
      #1 chk($sformatf("vec%0d rd mflo", i), rd_data, tbl[i].elo);
      op = OP_NOP;
    end

    // Back-to-back issue with an ignored mid-flight start.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("b2b busy before fall", {31'd0, busy}, 32'd1);
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_NOP;
    chk("b2b first hi", hi, 32'h1);
    chk("b2b first lo", lo, 32'hFFFFFFFE);
    chk("b2b second busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b second cycles", n, MC);
    chk("b2b second hi", hi, 32'h0);
    chk("b2b second lo", lo, 32'h9);

    // Reset in the third busy cycle aborts without commit.
    issue(OP_MTHI, 32'h55, 32'd0);
    issue(OP_MULT, 32'd5, 32'd5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort busy before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort late hi", hi, 32'd0);
    chk("abort late lo", lo, 32'd0);
    chk("abort late busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
